// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite encodings for the memory slave and future AHB slaves:
//   - HTRANS transfer-type encodings
//   - HSIZE transfer-size enum
//   - HRESP response encodings
//   - ahb_mem_state_e : data-phase state machine of ahb_mem_slave
// ----------------------------------------------------------------------------
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_mem_state_e;

endpackage

// File: rtl/ahb_lane_decode.sv
// ----------------------------------------------------------------------------
// ahb_lane_decode
// Combinational byte-lane decoder for AHB slaves (little-endian).
// Parameters:
//   DATA_W   : data bus width in bits (32 or 64)
// Ports:
//   hsize    in  3        : transfer size (bytes = 1 << hsize)
//   boff     in  BOFF_W   : byte offset of the address within a bus word
//   be       out DATA_W/8 : byte-enable mask of the lanes touched
//   oversize out 1        : transfer is wider than the data bus
//   misalign out 1        : address not aligned to the transfer size
// ----------------------------------------------------------------------------
module ahb_lane_decode #(
    parameter int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int BOFF_W = $clog2(NB)
) (
    input  logic [2:0]        hsize,
    input  logic [BOFF_W-1:0] boff,
    output logic [NB-1:0]     be,
    output logic              oversize,
    output logic              misalign
);

    localparam logic [10:0] DATA_BITS = 11'(DATA_W);

    logic [7:0] size_bytes;
    logic [8:0] lane_lo;
    logic [8:0] lane_hi;

    assign size_bytes = 8'd1 << hsize;
    assign oversize   = {size_bytes, 3'b000} > DATA_BITS;
    assign misalign   = ({{(8-BOFF_W){1'b0}}, boff} & (size_bytes - 8'd1)) != 8'd0;

    // Lanes covered: [boff, boff + size_bytes)
    assign lane_lo = {{(9-BOFF_W){1'b0}}, boff};
    assign lane_hi = lane_lo + {1'b0, size_bytes};

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        localparam logic [8:0] LANE = 9'(gi);
        assign be[gi] = (LANE >= lane_lo) && (LANE < lane_hi);
    end

endmodule

// File: rtl/ahb_mem_slave.sv
// ----------------------------------------------------------------------------
// ahb_mem_slave
// AHB-Lite memory slave with configurable width, depth, base address and
// wait states. Out-of-range, oversize and misaligned accesses receive the
// two-cycle ERROR response and never modify memory.
// Optional build macro:
//   AHB_MEM_SLAVE_RANDOM_WAIT_EN : per-transfer wait count drawn from a
//                                  16-bit LFSR, N = lfsr[3:0] mod (WAIT_STATES+1)
// Ports:
//   hclk, hreset        : clock, asynchronous active-high reset
//   HSEL, HADDR, HWRITE,
//   HTRANS, HSIZE       : address-phase controls
//   HBURST, HPROT       : accepted, not used (each beat decoded alone)
//   HWDATA              : write data (data phase)
//   HREADY              : bus-level ready
//   HREADYOUT, HRESP,
//   HRDATA              : slave response
// ----------------------------------------------------------------------------
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_STATES = 0
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic              HWRITE,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DATA_W-1:0] HRDATA
);

    localparam int NB     = DATA_W / 8;
    localparam int BOFF_W = $clog2(NB);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(DEPTH * NB);

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

    // ---------------- address-phase decode ----------------
    logic [BOFF_W-1:0] addr_boff;
    logic [IDX_W-1:0]  addr_idx;
    logic [NB-1:0]     lane_be;
    logic              lane_oversize;
    logic              lane_misalign;
    logic [ADDR_W:0]   addr_off;
    logic              in_range;
    logic              cap;
    logic              cap_err;
    logic              cap_ok;
    logic [3:0]        wait_n;

    assign addr_boff = HADDR[BOFF_W-1:0];
    // BASE_ADDR is aligned to the memory size, so the word index is a plain slice
    assign addr_idx  = HADDR[BOFF_W +: IDX_W];
    assign addr_off  = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign in_range  = (HADDR >= BASE_ADDR) && (addr_off < MEM_BYTES);

    ahb_lane_decode #(.DATA_W(DATA_W)) u_lane_decode (
        .hsize    (HSIZE),
        .boff     (addr_boff),
        .be       (lane_be),
        .oversize (lane_oversize),
        .misalign (lane_misalign)
    );

    assign cap     = HSEL & HREADY & HTRANS[1];
    assign cap_err = cap & (~in_range | lane_oversize | lane_misalign);
    assign cap_ok  = cap & ~cap_err;

`ifdef AHB_MEM_SLAVE_RANDOM_WAIT_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            lfsr_reg <= 16'hACE1;
        end else if (cap) begin
            // Fibonacci taps 16,14,13,11
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign wait_n = 4'(lfsr_reg[3:0] % (WAIT_STATES + 1));
`else
    assign wait_n = 4'(WAIT_STATES);
`endif

    // ---------------- data-phase state machine ----------------
    ahb_mem_state_e state_reg, state_next;
    logic [3:0]     wait_cnt_reg, wait_cnt_next;
    logic           ready;
    logic           resp;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        ready         = 1'b1;
        resp          = HRESP_OKAY;
        case (state_reg)
            ST_IDLE: ;
            ST_WAIT: begin
                ready         = 1'b0;
                wait_cnt_next = wait_cnt_reg - 4'd1;
                if (wait_cnt_next == 4'd0) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERR1: begin
                ready      = 1'b0;
                resp       = HRESP_ERROR;
                state_next = ST_ERR2;
            end
            ST_ERR2: begin
                resp       = HRESP_ERROR;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // A new capture overrides the state's own successor
        if (cap_err) begin
            state_next    = ST_ERR1;
            wait_cnt_next = 4'd0;
        end else if (cap_ok) begin
            state_next    = (wait_n != 4'd0) ? ST_WAIT : ST_IDLE;
            wait_cnt_next = wait_n;
        end
    end

    assign HREADYOUT = ready;
    assign HRESP     = resp;

    // ---------------- transfer bookkeeping ----------------
    logic             wr_pend_reg;
    logic [IDX_W-1:0] wr_idx_reg;
    logic [NB-1:0]    wr_be_reg;
    logic             rd_valid_reg;
    logic             wr_commit;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            wr_pend_reg  <= 1'b0;
            wr_idx_reg   <= '0;
            wr_be_reg    <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            if (cap) begin
                wr_pend_reg  <= cap_ok & HWRITE;
                wr_idx_reg   <= addr_idx;
                wr_be_reg    <= lane_be;
                rd_valid_reg <= cap_ok & ~HWRITE;
            end else if (ready) begin
                wr_pend_reg  <= 1'b0;
                rd_valid_reg <= 1'b0;
            end
        end
    end

    // A write lands on the last data-phase cycle, when HWDATA is valid
    assign wr_commit = wr_pend_reg & ready;

    // ---------------- storage ----------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mem_q_reg;
    logic [DATA_W-1:0] fwd_data_reg;
    logic [NB-1:0]     fwd_be_reg;

    always_ff @(posedge hclk) begin
        if (wr_commit) begin
            for (int b = 0; b < NB; b++) begin
                if (wr_be_reg[b]) begin
                    mem[wr_idx_reg][b*8 +: 8] <= HWDATA[b*8 +: 8];
                end
            end
        end
        if (cap) begin
            // Array read returns pre-write data; a write committing on this
            // same edge to the same word is merged back in on the output.
            mem_q_reg    <= mem[addr_idx];
            fwd_data_reg <= HWDATA;
            fwd_be_reg   <= (wr_commit && (wr_idx_reg == addr_idx)) ? wr_be_reg : '0;
        end
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_rdata
        assign HRDATA[gi*8 +: 8] = !rd_valid_reg   ? 8'h00 :
                                   fwd_be_reg[gi] ? fwd_data_reg[gi*8 +: 8] :
                                                    mem_q_reg[gi*8 +: 8];
    end

endmodule
